// File: rtl/fb_pkg.sv
// Shared framebuffer constants, scan FSM states and the page-byte payload.
// Optional build macro used by the scanner: FB_SCAN_ROT180_EN.
package fb_pkg;

    localparam int unsigned H_PIXELS    = 128;
    localparam int unsigned V_PIXELS    = 64;
    localparam int unsigned PAGES       = V_PIXELS / 8;
    localparam int unsigned FRAME_BYTES = H_PIXELS * PAGES;
    localparam int unsigned COL_W       = $clog2(H_PIXELS);
    localparam int unsigned PAGE_W      = 3;
    localparam int unsigned POS_W       = 8;

    localparam logic RMODE_ROW = 1'b0;
    localparam logic RMODE_COL = 1'b1;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_REQ,
        SCAN_GAP,
        SCAN_DRAIN
    } scan_state_t;

    // One page byte plus its framing flags; last marks the final byte of a frame.
    typedef struct packed {
        logic       sof;
        logic       sop;
        logic       last;
        logic [7:0] data;
    } page_byte_t;

    // Column bytes arrive MSB = top row; panel bytes want bit0 = top row.
    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

endpackage

// File: rtl/fb_page_scanner_if.sv
// Framebuffer column-read port and page-byte stream of the page scanner.
interface fb_page_scanner_if;

    logic       fb_re;
    logic [7:0] fb_r_xpos;
    logic [7:0] fb_r_ypos;
    logic       fb_r_mode;
    logic       fb_r_data_valid;
    logic [7:0] fb_dout;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_sop;

    modport master (
        output fb_re, fb_r_xpos, fb_r_ypos, fb_r_mode,
        output out_data, out_valid, out_sof, out_sop,
        input  fb_r_data_valid, fb_dout, out_ready
    );

    modport slave (
        input  fb_re, fb_r_xpos, fb_r_ypos, fb_r_mode,
        input  out_data, out_valid, out_sof, out_sop,
        output fb_r_data_valid, fb_dout, out_ready
    );

endinterface

// File: rtl/fb_scan_counter.sv
// Column/page position counter for the page scanner.
// FB_SCAN_ROT180_EN reverses the walk (col 127..0, page 7..0).
module fb_scan_counter
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    output logic [COL_W-1:0]  col,
    output logic [PAGE_W-1:0] page,
    output logic              first_col_c,
    output logic              first_pos_c,
    output logic              last_pos_c
);

    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_PIXELS - 1);
    localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES - 1);

`ifdef FB_SCAN_ROT180_EN
    localparam logic [COL_W-1:0]  COL_START  = COL_MAX;
    localparam logic [PAGE_W-1:0] PAGE_START = PAGE_MAX;
    localparam logic [COL_W-1:0]  COL_END    = '0;
    localparam logic [PAGE_W-1:0] PAGE_END   = '0;
    localparam logic [COL_W-1:0]  COL_STEP   = '1;
    localparam logic [PAGE_W-1:0] PAGE_STEP  = '1;
`else
    localparam logic [COL_W-1:0]  COL_START  = '0;
    localparam logic [PAGE_W-1:0] PAGE_START = '0;
    localparam logic [COL_W-1:0]  COL_END    = COL_MAX;
    localparam logic [PAGE_W-1:0] PAGE_END   = PAGE_MAX;
    localparam logic [COL_W-1:0]  COL_STEP   = COL_W'(1);
    localparam logic [PAGE_W-1:0] PAGE_STEP  = PAGE_W'(1);
`endif

    logic [COL_W-1:0]  col_q, col_d;
    logic [PAGE_W-1:0] page_q, page_d;

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            page_q <= '0;
        end else begin
            col_q  <= col_d;
            page_q <= page_d;
        end
    end

    // Load the frame start or step one column, wrapping into the next page.
    always_comb begin
        col_d  = col_q;
        page_d = page_q;
        if (load) begin
            col_d  = COL_START;
            page_d = PAGE_START;
        end else if (advance) begin
            if (col_q == COL_END) begin
                col_d  = COL_START;
                page_d = PAGE_W'(page_q + PAGE_STEP);
            end else begin
                col_d  = COL_W'(col_q + COL_STEP);
            end
        end
    end

    assign col         = col_q;
    assign page        = page_q;
    assign first_col_c = (col_q == COL_START);
    assign first_pos_c = (col_q == COL_START) && (page_q == PAGE_START);
    assign last_pos_c  = (col_q == COL_END) && (page_q == PAGE_END);

endmodule

// File: rtl/fb_page_scanner.sv
// Display-refresh initiator: walks the framebuffer page by page in column-read
// mode and streams panel page bytes over valid/ready.
// Build option FB_SCAN_ROT180_EN: upside-down panel (reverse walk, no bit reversal).
module fb_page_scanner
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fb_ready,
    output logic              busy,
    output logic              frame_done,
    fb_page_scanner_if.master bus
);

    scan_state_t       state_q, state_d;
    logic              busy_q, busy_d;
    logic              fb_re_q, fb_re_d;
    logic              full_q, full_d;
    page_byte_t        out_q, out_d;

    logic              cnt_load;
    logic              cnt_adv;
    logic              capture;
    logic              drain;
    logic [COL_W-1:0]  col;
    logic [PAGE_W-1:0] page;
    logic              first_col_c;
    logic              first_pos_c;
    logic              last_pos_c;
    logic [7:0]        cap_data_c;

    fb_scan_counter u_cnt (
        .clk         (clk),
        .rst         (rst),
        .load        (cnt_load),
        .advance     (cnt_adv),
        .col         (col),
        .page        (page),
        .first_col_c (first_col_c),
        .first_pos_c (first_pos_c),
        .last_pos_c  (last_pos_c)
    );

`ifdef FB_SCAN_ROT180_EN
    assign cap_data_c = bus.fb_dout;
`else
    assign cap_data_c = bitrev8(bus.fb_dout);
`endif

    assign drain = full_q && bus.out_ready;

    // State, request and output-register flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN_IDLE;
            busy_q  <= 1'b0;
            fb_re_q <= 1'b0;
            full_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            fb_re_q <= fb_re_d;
            full_q  <= full_d;
            out_q   <= out_d;
        end
    end

    // Fetch FSM: request a column, capture it once the output slot frees, idle one GAP cycle.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        fb_re_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_adv  = 1'b0;
        capture  = 1'b0;
        case (state_q)
            SCAN_IDLE: begin
                if (start && fb_ready) begin
                    cnt_load = 1'b1;
                    busy_d   = 1'b1;
                    fb_re_d  = 1'b1;
                    state_d  = SCAN_REQ;
                end
            end
            SCAN_REQ: begin
                fb_re_d = 1'b1;
                if (bus.fb_r_data_valid && (!full_q || bus.out_ready)) begin
                    capture = 1'b1;
                    fb_re_d = 1'b0;
                    state_d = SCAN_GAP;
                end
            end
            SCAN_GAP: begin
                cnt_adv = 1'b1;
                if (last_pos_c) begin
                    state_d = SCAN_DRAIN;
                end else begin
                    fb_re_d = 1'b1;
                    state_d = SCAN_REQ;
                end
            end
            SCAN_DRAIN: begin
                if (!full_q || bus.out_ready) begin
                    busy_d  = 1'b0;
                    state_d = SCAN_IDLE;
                end
            end
            default: begin
                state_d = SCAN_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // One-entry output register; a load wins over a same-cycle drain.
    always_comb begin
        full_d = full_q;
        out_d  = out_q;
        if (drain) begin
            full_d = 1'b0;
            out_d  = '0;
        end
        if (capture) begin
            full_d     = 1'b1;
            out_d.data = cap_data_c;
            out_d.sof  = first_pos_c;
            out_d.sop  = first_col_c;
            out_d.last = last_pos_c;
        end
    end

    assign busy          = busy_q;
    assign frame_done    = drain && out_q.last;
    assign bus.fb_re     = fb_re_q;
    assign bus.fb_r_xpos = POS_W'(col);
    assign bus.fb_r_ypos = POS_W'({page, 3'b000});
    assign bus.fb_r_mode = RMODE_COL;
    assign bus.out_data  = out_q.data;
    assign bus.out_valid = full_q;
    assign bus.out_sof   = out_q.sof;
    assign bus.out_sop   = out_q.sop;

endmodule

// File: tb/tb_fb_page_scanner.sv
// Bench for fb_page_scanner: framebuffer model with variable read latency,
// random downstream back-pressure, whole-frame reference built from the pixel map.
module tb_fb_page_scanner;
    import fb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic fb_ready;
    logic busy;
    logic frame_done;

    always #5 clk = ~clk;

    fb_page_scanner_if bus ();

    fb_page_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fb_ready   (fb_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

`ifdef FB_SCAN_ROT180_EN
    localparam logic [7:0] SX = 8'd127;
    localparam logic [7:0] SY = 8'd56;
`else
    localparam logic [7:0] SX = 8'd0;
    localparam logic [7:0] SY = 8'd0;
`endif

    int total = 0;
    int bad   = 0;

    bit pix [V_PIXELS][H_PIXELS];   // pix[y][x]
    int rdy_mode;
    int lat_min;
    int lat_max;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       sop;
    } rec_t;

    rec_t got [$];
    int   fd_idx [$];
    int   stab_bad = 0;
    int   gap_bad  = 0;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       fb_ready;
        logic       exp_busy;
        logic       exp_re;
        logic [7:0] exp_x;
        logic [7:0] exp_y;
    } vec_t;

    // Framebuffer column read: MSB is row y, bit (7-k) is row y+k.
    function automatic logic [7:0] col_byte(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++)
            if (int'(y) + k < int'(V_PIXELS) && int'(x) < int'(H_PIXELS))
                b[7-k] = pix[int'(y) + k][int'(x)];
        return b;
    endfunction

    // Expected i-th byte of a frame, straight from the pixel map.
    function automatic logic [7:0] exp_byte(input int i);
        logic [7:0] b;
        int pg;
        int cl;
        b = 8'h00;
`ifdef FB_SCAN_ROT180_EN
        pg = int'(PAGES) - 1 - i / int'(H_PIXELS);
        cl = int'(H_PIXELS) - 1 - i % int'(H_PIXELS);
        for (int k = 0; k < 8; k++) b[7-k] = pix[pg*8 + k][cl];
`else
        pg = i / int'(H_PIXELS);
        cl = i % int'(H_PIXELS);
        for (int k = 0; k < 8; k++) b[k] = pix[pg*8 + k][cl];
`endif
        return b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Framebuffer model, downstream ready and stream monitor.
    initial begin : env
        int lat_cnt;
        int lat_tgt;
        int cyc;
        int low_run;
        logic prev_re;
        logic prev_busy;
        logic [7:0] px;
        logic [7:0] py;
        rec_t r;
        lat_cnt = 0; lat_tgt = 11; cyc = 0; low_run = 0;
        prev_re = 1'b0; prev_busy = 1'b0; px = 8'h00; py = 8'h00;
        bus.out_ready = 1'b0;
        bus.fb_r_data_valid = 1'b0;
        bus.fb_dout = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if ((cyc % 3000) >= 1000 && (cyc % 3000) < 1050) bus.out_ready = 1'b0;
                    else bus.out_ready = 1'($urandom_range(0, 1));
                end
            endcase
            if (!bus.fb_re) begin
                lat_cnt = 0;
                lat_tgt = $urandom_range(lat_min, lat_max);
                bus.fb_r_data_valid = 1'b0;
            end else begin
                if (lat_cnt < lat_tgt) lat_cnt++;
                bus.fb_r_data_valid = (lat_cnt >= lat_tgt);
                bus.fb_dout = col_byte(bus.fb_r_xpos, bus.fb_r_ypos);
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                r.d = bus.out_data; r.sof = bus.out_sof; r.sop = bus.out_sop;
                got.push_back(r);
            end
            if (frame_done) fd_idx.push_back(got.size() - 1);
            if (bus.fb_re && prev_re && (bus.fb_r_xpos != px || bus.fb_r_ypos != py)) stab_bad++;
            if (bus.fb_re && !prev_re && prev_busy && low_run != 1) gap_bad++;
            low_run   = bus.fb_re ? 0 : low_run + 1;
            prev_re   = bus.fb_re;
            prev_busy = busy;
            px        = bus.fb_r_xpos;
            py        = bus.fb_r_ypos;
        end
    end

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_frame(input string nm, input int b_got, input int b_fd,
                               input int b_stab, input int b_gap);
        int n;
        int nbad;
        int fbad;
        int first;
        rec_t r;
        n = got.size() - b_got;
        chk({nm, "_bytes"}, n, int'(FRAME_BYTES));
        if (n >= int'(FRAME_BYTES)) begin
            nbad = 0; fbad = 0; first = -1;
            for (int i = 0; i < int'(FRAME_BYTES); i++) begin
                r = got[b_got + i];
                if (r.d !== exp_byte(i)) begin
                    nbad++;
                    if (first < 0) first = i;
                end
                if (r.sof !== 1'(i == 0) || r.sop !== 1'(i % int'(H_PIXELS) == 0)) fbad++;
            end
            chk({nm, "_data_errors"}, nbad, 0);
            if (first >= 0)
                $display("  first data error at byte %0d: got %02h want %02h",
                         first, got[b_got + first].d, exp_byte(first));
            chk({nm, "_flag_errors"}, fbad, 0);
        end
        chk({nm, "_frame_done_count"}, fd_idx.size() - b_fd, 1);
        if (fd_idx.size() > b_fd)
            chk({nm, "_frame_done_pos"}, fd_idx[b_fd] - b_got, int'(FRAME_BYTES) - 1);
        chk({nm, "_addr_stable"}, stab_bad - b_stab, 0);
        chk({nm, "_gap_cycle"}, gap_bad - b_gap, 0);
        chk({nm, "_busy_low"}, int'(busy), 0);
    endtask

    task automatic run_frame(input string nm, input int mode, input bit poke, output int base);
        int b_fd;
        int b_stab;
        int b_gap;
        int cyc;
        bit re_seen;
        rdy_mode = mode;
        base   = got.size();
        b_fd   = fd_idx.size();
        b_stab = stab_bad;
        b_gap  = gap_bad;
        pulse_start();
        cyc = 0;
        while (busy && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (poke) start = (cyc == 300 || cyc == 1500);
        end
        start = 1'b0;
        chk({nm, "_finished"}, int'(cyc < 30000), 1);
        @(negedge clk);
        #2;
        check_frame(nm, base, b_fd, b_stab, b_gap);
        if (poke) begin
            re_seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                #1;
                if (bus.fb_re || busy) re_seen = 1'b1;
            end
            chk({nm, "_no_queued_start"}, int'(re_seen), 0);
            chk({nm, "_frames_total"}, fd_idx.size() - b_fd, 1);
        end
    endtask

    initial begin : main
        vec_t tbl [9];
        int base;
        int cyc;

        rst = 1'b1; start = 1'b0; fb_ready = 1'b0;
        rdy_mode = 0; lat_min = 11; lat_max = 11;
        foreach (pix[y, x]) pix[y][x] = 1'b0;

        //          rst   start fb_rdy busy  re    x      y
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, SX,   SY  };
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, SX,   SY  };
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};

        // Reset values, start gating by fb_ready, scan launch and abort.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; start = tbl[i].start; fb_ready = tbl[i].fb_ready;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
            chk($sformatf("vec%0d_fb_re", i), int'(bus.fb_re), int'(tbl[i].exp_re));
            chk($sformatf("vec%0d_xpos", i), int'(bus.fb_r_xpos), int'(tbl[i].exp_x));
            chk($sformatf("vec%0d_ypos", i), int'(bus.fb_r_ypos), int'(tbl[i].exp_y));
            chk($sformatf("vec%0d_out_valid", i), int'(bus.out_valid), 0);
            chk($sformatf("vec%0d_frame_done", i), int'(frame_done), 0);
            chk($sformatf("vec%0d_rmode", i), int'(bus.fb_r_mode), 1);
        end
        start = 1'b0; fb_ready = 1'b1;

        // Cleared framebuffer, always ready, full read latency.
        run_frame("clear", 0, 1'b0, base);

        // Marker pixels under random back-pressure; start pokes while busy.
        lat_min = 1; lat_max = 4;
        pix[0][0] = 1'b1;
        pix[13][5] = 1'b1;
        for (int r = 56; r < 64; r++) pix[r][127] = 1'b1;
        run_frame("markers", 1, 1'b1, base);
        if (got.size() >= base + int'(FRAME_BYTES)) begin
`ifdef FB_SCAN_ROT180_EN
            chk("rot_byte1023", int'(got[base + 1023].d), 8'h80);
            chk("rot_byte890", int'(got[base + 890].d), 8'h04);
            chk("rot_byte0", int'(got[base].d), 8'hFF);
`else
            chk("byte0", int'(got[base].d), 8'h01);
            chk("byte133", int'(got[base + 133].d), 8'h20);
            chk("byte1023", int'(got[base + 1023].d), 8'hFF);
`endif
        end

        // Random image with a 50-cycle ready stall inside the frame.
        foreach (pix[y, x]) pix[y][x] = ($urandom_range(0, 3) == 0);
        run_frame("random", 2, 1'b0, base);

        // Reset in the middle of a frame, then a clean restart.
        rdy_mode = 1;
        base = got.size();
        pulse_start();
        cyc = 0;
        while (got.size() - base < 500 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_reached_500", int'(cyc < 20000), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_fb_re", int'(bus.fb_re), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame("after_rst", 1, 1'b0, base);
        if (got.size() > base) chk("after_rst_sof", int'(got[base].sof), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
